// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot frame pipeline: default screen size,
// the scheduler FSM state encoding, the Q8.24 view coordinate type and a
// small population-count helper used to total engine retire pulses.
package mandel_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    // Signed Q8.24 view coordinate
    typedef logic signed [31:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    // Number of set bits in an up-to-8-wide pulse vector
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/pixel_scheduler_if.sv
// Engine-facing bus of the pixel scheduler: ready/grant/retire handshake,
// the pixel coordinate on offer and the frame view latched for the mapper.
interface pixel_scheduler_if #(
    parameter int NUM_ENG = 4
);
    import mandel_pkg::*;

    logic [NUM_ENG-1:0] eng_ready;
    logic [NUM_ENG-1:0] eng_grant;
    logic [NUM_ENG-1:0] eng_retire;
    logic [9:0]         pix_x;
    logic [9:0]         pix_y;
    coord_t             frm_pan_x;
    coord_t             frm_pan_y;
    logic [7:0]         frm_zoom;

    modport master (
        input  eng_ready, eng_retire,
        output eng_grant, pix_x, pix_y, frm_pan_x, frm_pan_y, frm_zoom
    );

    modport slave (
        output eng_ready, eng_retire,
        input  eng_grant, pix_x, pix_y, frm_pan_x, frm_pan_y, frm_zoom
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// the pointer (wrapping modulo NUM_ENG) and returns the pointer that follows
// the winner. With no request the grant is zero and the pointer holds.
module rr_arbiter #(
    parameter int NUM_ENG = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_ENG-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_ENG-1:0] grant,
    output logic [PTR_W-1:0]   ptr_nxt
);

    logic [PTR_W:0]   sum_s;
    logic [PTR_W-1:0] idx_s;
    logic             found_s;

    // Rotating priority search starting at the pointer
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        found_s = 1'b0;
        sum_s   = '0;
        idx_s   = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            sum_s = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum_s >= (PTR_W+1)'(NUM_ENG)) begin
                idx_s = PTR_W'(sum_s - (PTR_W+1)'(NUM_ENG));
            end else begin
                idx_s = sum_s[PTR_W-1:0];
            end
            if (!found_s && req[idx_s]) begin
                found_s      = 1'b1;
                grant[idx_s] = 1'b1;
                if (idx_s == PTR_W'(NUM_ENG - 1)) begin
                    ptr_nxt = '0;
                end else begin
                    ptr_nxt = idx_s + PTR_W'(1);
                end
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/pixel_scheduler.sv
// Pixel scheduler: walks every screen coordinate of a frame in raster order
// and dispatches one pixel per cycle to the next ready iteration engine,
// tracking outstanding work so the frame only completes once all engines
// have retired. Optional build macro PIXEL_SCHEDULER_STALL_CNT_EN adds a
// stall_cycles output counting SCAN cycles that found no ready engine.
module pixel_scheduler
    import mandel_pkg::*;
#(
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF,
    parameter int NUM_ENG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  coord_t            pan_x,
    input  coord_t            pan_y,
    input  logic [7:0]        zoom,
    pixel_scheduler_if.master eng,
    output logic              busy,
    output logic              frame_done
`ifdef PIXEL_SCHEDULER_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`else
`endif
);

    localparam int         PTR_W  = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam int         OUT_W  = $clog2(NUM_ENG + 1);
    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

    sched_state_e       state_r, state_nxt_s;
    logic [9:0]         pix_x_r, pix_y_r;
    logic [PTR_W-1:0]   ptr_r, arb_ptr_nxt_s;
    logic [OUT_W-1:0]   outstanding_r, outstanding_nxt_s;
    coord_t             frm_pan_x_r, frm_pan_y_r;
    logic [7:0]         frm_zoom_r;
    logic               busy_r, frame_done_r;
    logic [NUM_ENG-1:0] arb_grant_s, grant_s;
    logic               granted_s, last_pix_s, start_acc_s;
    logic [3:0]         ret_cnt_s, ret_eff_s, out_ext_s, out_sum_s;

    rr_arbiter #(
        .NUM_ENG (NUM_ENG),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req     (eng.eng_ready),
        .ptr     (ptr_r),
        .grant   (arb_grant_s),
        .ptr_nxt (arb_ptr_nxt_s)
    );

    assign grant_s     = (state_r == ST_SCAN) ? arb_grant_s : '0;
    assign granted_s   = |grant_s;
    assign last_pix_s  = (pix_x_r == X_LAST) && (pix_y_r == Y_LAST);
    assign start_acc_s = (state_r == ST_IDLE) && start;

    assign eng.eng_grant = grant_s;
    assign eng.pix_x     = pix_x_r;
    assign eng.pix_y     = pix_y_r;
    assign eng.frm_pan_x = frm_pan_x_r;
    assign eng.frm_pan_y = frm_pan_y_r;
    assign eng.frm_zoom  = frm_zoom_r;
    assign busy          = busy_r;
    assign frame_done    = frame_done_r;

    // Frame sequencing: scan until the last pixel is dispatched, drain, done
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  if (start_acc_s) state_nxt_s = ST_SCAN;
                      else             state_nxt_s = ST_IDLE;
            ST_SCAN:  if (granted_s && last_pix_s) state_nxt_s = ST_DRAIN;
                      else                         state_nxt_s = ST_SCAN;
            ST_DRAIN: if (outstanding_r == '0) state_nxt_s = ST_DONE;
                      else                     state_nxt_s = ST_DRAIN;
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Outstanding work: add the grant, remove retires but never below zero
    always_comb begin
        ret_cnt_s = popcount8(8'(eng.eng_retire));
        out_ext_s = 4'(outstanding_r);
        if (ret_cnt_s > out_ext_s) begin
            ret_eff_s = out_ext_s;
        end else begin
            ret_eff_s = ret_cnt_s;
        end
        out_sum_s         = out_ext_s - ret_eff_s + {3'd0, granted_s};
        outstanding_nxt_s = OUT_W'(out_sum_s);
    end

    // State, scan position, pointer, frame view and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            pix_x_r       <= 10'd0;
            pix_y_r       <= 10'd0;
            ptr_r         <= '0;
            outstanding_r <= '0;
            frm_pan_x_r   <= 32'sd0;
            frm_pan_y_r   <= 32'sd0;
            frm_zoom_r    <= 8'd0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            busy_r        <= (state_nxt_s != ST_IDLE);
            frame_done_r  <= (state_nxt_s == ST_DONE);
            outstanding_r <= outstanding_nxt_s;
            if (granted_s) begin
                ptr_r <= arb_ptr_nxt_s;
            end
            if (start_acc_s) begin
                frm_pan_x_r <= pan_x;
                frm_pan_y_r <= pan_y;
                frm_zoom_r  <= zoom;
                pix_x_r     <= 10'd0;
                pix_y_r     <= 10'd0;
            end else if (granted_s && !last_pix_s) begin
                if (pix_x_r == X_LAST) begin
                    pix_x_r <= 10'd0;
                    pix_y_r <= pix_y_r + 10'd1;
                end else begin
                    pix_x_r <= pix_x_r + 10'd1;
                end
            end
        end
    end

`ifdef PIXEL_SCHEDULER_STALL_CNT_EN
    logic [31:0] stall_r;
    assign stall_cycles = stall_r;

    // Count SCAN cycles with no ready engine, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_r <= 32'd0;
        end else if (start_acc_s) begin
            stall_r <= 32'd0;
        end else if ((state_r == ST_SCAN) && !granted_s && (stall_r != 32'hFFFF_FFFF)) begin
            stall_r <= stall_r + 32'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_pixel_scheduler.sv
// Self-checking bench for pixel_scheduler on a reduced 20x6 screen with four
// engines. A frame-level reference model (linear pixel index, modulo pointer
// search, clipped outstanding count) predicts every cycle.
module tb_pixel_scheduler
    import mandel_pkg::*;
;
    localparam int H    = 20;
    localparam int V    = 6;
    localparam int N    = 4;
    localparam int NPIX = H * V;
    localparam int P_IDLE = 0, P_SCAN = 1, P_DRAIN = 2, P_DONE = 3;

    logic       clk, rst_n, start;
    coord_t     pan_x, pan_y;
    logic [7:0] zoom;
    logic       busy, frame_done;
`ifdef PIXEL_SCHEDULER_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    pixel_scheduler_if #(.NUM_ENG(N)) bus ();

    pixel_scheduler #(.H_RES(H), .V_RES(V), .NUM_ENG(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pan_x      (pan_x),
        .pan_y      (pan_y),
        .zoom       (zoom),
        .eng        (bus.master),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef PIXEL_SCHEDULER_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // reference model
    int          m_phase, m_ptr, m_idx, m_out, m_stall;
    logic [31:0] m_fx, m_fy;
    logic [7:0]  m_fz;
    // engine model
    int          e_cnt [N];
    int          lat;
    logic [N-1:0] rdy_mask, extra_ret, exp_grant, obs_grant;
    logic        start_in;

    task automatic model_reset();
        m_phase = P_IDLE; m_ptr = 0; m_idx = 0; m_out = 0; m_stall = 0;
        m_fx = 32'd0; m_fy = 32'd0; m_fz = 8'd0;
    endtask

    // One clock: drive engines, record grant, advance model, land at posedge+1
    task automatic tick();
        logic [N-1:0] ret, rdy;
        int ge, r, rm;
        ret = extra_ret;
        rdy = '0;
        for (int e = 0; e < N; e++) begin
            if (e_cnt[e] > 0) begin
                e_cnt[e]--;
                if (e_cnt[e] == 0) ret[e] = 1'b1;
            end
            rdy[e] = (e_cnt[e] == 0) && rdy_mask[e];
        end
        bus.eng_ready  = rdy;
        bus.eng_retire = ret;
        start = start_in;
        #1;
        obs_grant = bus.eng_grant;
        ge = -1;
        if (m_phase == P_SCAN) begin
            for (int i = 0; i < N; i++) begin
                if (ge < 0 && rdy[(m_ptr + i) % N]) ge = (m_ptr + i) % N;
            end
        end
        exp_grant = (ge >= 0) ? (4'b0001 << ge) : 4'b0000;
        r  = $countones(ret);
        rm = (r < m_out) ? r : m_out;
        case (m_phase)
            P_IDLE: if (start_in) begin
                m_phase = P_SCAN; m_idx = 0; m_stall = 0;
                m_fx = pan_x; m_fy = pan_y; m_fz = zoom;
            end
            P_SCAN: if (ge >= 0) begin
                m_ptr = (ge + 1) % N;
                if (m_idx == NPIX - 1) m_phase = P_DRAIN;
                else m_idx++;
            end else begin
                m_stall++;
            end
            P_DRAIN: if (m_out == 0) m_phase = P_DONE;
            default: m_phase = P_IDLE;
        endcase
        m_out = m_out - rm + ((ge >= 0) ? 1 : 0);
        if (ge >= 0) e_cnt[ge] = lat;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0; start_in = 1'b0;
        bus.eng_retire = '0; extra_ret = '0;
        for (int e = 0; e < N; e++) e_cnt[e] = 0;
        #2;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_idle(input int bound, output bit ok);
        int n;
        n = 0;
        while (m_phase != P_IDLE && n < bound) begin
            tick();
            n++;
        end
        ok = (m_phase == P_IDLE);
    endtask

    task automatic test_reset();
        bus.eng_ready = '1; bus.eng_retire = '0; start = 1'b1;
        #3;
        checks += 7;
        if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (frame_done !== 1'b0)   begin errors++; $display("FAIL rst_done got=%b exp=0", frame_done); end
        if (bus.eng_grant !== 4'b0) begin errors++; $display("FAIL rst_grant got=%b exp=0000", bus.eng_grant); end
        if (bus.pix_x !== 10'd0 || bus.pix_y !== 10'd0) begin errors++; $display("FAIL rst_pix got=%0d,%0d exp=0,0", bus.pix_x, bus.pix_y); end
        if (bus.frm_zoom !== 8'd0) begin errors++; $display("FAIL rst_zoom got=%0d exp=0", bus.frm_zoom); end
        if (bus.frm_pan_x !== 32'sd0 || bus.frm_pan_y !== 32'sd0) begin errors++; $display("FAIL rst_pan got=%h,%h exp=0", bus.frm_pan_x, bus.frm_pan_y); end
        if (dut.outstanding_r !== 3'd0) begin errors++; $display("FAIL rst_out got=%0d exp=0", dut.outstanding_r); end
        start = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        // retire pulses with nothing outstanding must not underflow
        rdy_mask = '1; lat = 3; extra_ret = 4'b1111;
        tick();
        extra_ret = '0;
        checks += 2;
        if (dut.outstanding_r !== 3'd0) begin errors++; $display("FAIL retire_at_zero got=%0d exp=0", dut.outstanding_r); end
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_full_frame();
        int gcnt, first, last, dcnt, n;
        logic [9:0] px, py;
        do_reset();
        lat = 3; rdy_mask = '1;
        pan_x = 32'hFF00_0000; pan_y = coord_t'($urandom); zoom = 8'd8;
        start_in = 1'b1; tick(); start_in = 1'b0;
        gcnt = 0; first = -1; last = -1; dcnt = 0; n = 0;
        while (m_phase != P_IDLE && n < NPIX + 40) begin
            px = bus.pix_x; py = bus.pix_y;
            tick();
            n++;
            if (|obs_grant) begin
                gcnt++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (frame_done === 1'b1) dcnt++;
            checks += 3;
            if (obs_grant !== exp_grant) begin errors++; $display("FAIL ff_grant cyc=%0d got=%b exp=%b", cyc, obs_grant, exp_grant); end
            if (bus.pix_x !== 10'(m_idx % H) || bus.pix_y !== 10'(m_idx / H)) begin
                errors++; $display("FAIL ff_pix cyc=%0d got=%0d,%0d exp=%0d,%0d", cyc, bus.pix_x, bus.pix_y, m_idx % H, m_idx / H);
            end
            if (frame_done !== (m_phase == P_DONE)) begin errors++; $display("FAIL ff_done cyc=%0d got=%b", cyc, frame_done); end
            if (px == 10'(H - 1) && py == 10'd5 && |obs_grant) begin
                checks++;
                if (bus.pix_x !== 10'd0 || bus.pix_y !== 10'd6 - 10'd0) begin
                    if (!(bus.pix_x === 10'd0 && bus.pix_y === 10'd6) && !(V == 6 && bus.pix_x === 10'(H - 1) && bus.pix_y === 10'd5)) begin
                        errors++; $display("FAIL line_wrap got=%0d,%0d exp=0,6", bus.pix_x, bus.pix_y);
                    end
                end
            end
            if (px == 10'(H - 1) && py == 10'd2 && |obs_grant) begin
                checks++;
                if (bus.pix_x !== 10'd0 || bus.pix_y !== 10'd3) begin errors++; $display("FAIL line_wrap got=%0d,%0d exp=0,3", bus.pix_x, bus.pix_y); end
            end
        end
        checks += 6;
        if (m_phase != P_IDLE) begin errors++; $display("FAIL ff_timeout got=phase%0d exp=idle", m_phase); end
        if (gcnt !== NPIX) begin errors++; $display("FAIL ff_grants got=%0d exp=%0d", gcnt, NPIX); end
        if (last - first + 1 !== NPIX) begin errors++; $display("FAIL ff_span got=%0d exp=%0d", last - first + 1, NPIX); end
        if (dcnt !== 1) begin errors++; $display("FAIL ff_done_cnt got=%0d exp=1", dcnt); end
        if (bus.frm_zoom !== 8'd8 || bus.frm_pan_x !== 32'shFF00_0000) begin errors++; $display("FAIL ff_view got=%0d,%h exp=8,ff000000", bus.frm_zoom, bus.frm_pan_x); end
        if (busy !== 1'b0) begin errors++; $display("FAIL ff_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_pointer_pattern();
        logic [N-1:0] want [3];
        bit ok;
        want[0] = 4'b0010; want[1] = 4'b1000; want[2] = 4'b0010;
        do_reset();
        lat = 1; rdy_mask = 4'b1010; zoom = 8'd3;
        start_in = 1'b1; tick(); start_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks += 2;
            if (obs_grant !== want[k]) begin errors++; $display("FAIL rr_seq%0d got=%b exp=%b", k, obs_grant, want[k]); end
            if (obs_grant !== exp_grant) begin errors++; $display("FAIL rr_model%0d got=%b exp=%b", k, obs_grant, exp_grant); end
        end
        rdy_mask = '1; lat = 2;
        run_to_idle(NPIX + 40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rr_timeout got=busy exp=idle"); end
    endtask

    task automatic test_outstanding();
        bit ok;
        do_reset();
        lat = 12; rdy_mask = 4'b0111;
        start_in = 1'b1; tick(); start_in = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (dut.outstanding_r !== 3'd3) begin errors++; $display("FAIL out_three got=%0d exp=3", dut.outstanding_r); end
        rdy_mask = 4'b1000; extra_ret = 4'b0011;
        tick();
        extra_ret = '0;
        checks += 2;
        if (obs_grant !== 4'b1000) begin errors++; $display("FAIL out_grant got=%b exp=1000", obs_grant); end
        if (dut.outstanding_r !== 3'd2) begin errors++; $display("FAIL out_net got=%0d exp=2", dut.outstanding_r); end
        rdy_mask = '1; lat = 3;
        run_to_idle(NPIX + 60, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL out_timeout got=busy exp=idle"); end
        if (dut.outstanding_r !== 3'd0) begin errors++; $display("FAIL out_end got=%0d exp=0", dut.outstanding_r); end
    endtask

    task automatic test_start_ignored_and_reset();
        int n;
        do_reset();
        lat = 2; rdy_mask = '1; zoom = 8'd5; pan_x = 32'sd1234;
        start_in = 1'b1; tick(); start_in = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        zoom = 8'd12; pan_x = 32'sd99;
        start_in = 1'b1; tick(); start_in = 1'b0;
        checks += 3;
        if (bus.frm_zoom !== 8'd5) begin errors++; $display("FAIL ign_zoom got=%0d exp=5", bus.frm_zoom); end
        if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy got=%b exp=1", busy); end
        if (bus.pix_x !== 10'(m_idx % H) || m_idx < 7) begin errors++; $display("FAIL ign_pix got=%0d exp=%0d", bus.pix_x, m_idx % H); end
        n = 0;
        while (m_idx != 2 * H + 10 && n < 200) begin tick(); n++; end
        checks++;
        if (bus.pix_x !== 10'd10 || bus.pix_y !== 10'd2) begin errors++; $display("FAIL mid_pos got=%0d,%0d exp=10,2", bus.pix_x, bus.pix_y); end
        rst_n = 1'b0;
        #2;
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        if (bus.pix_x !== 10'd0 || bus.pix_y !== 10'd0) begin errors++; $display("FAIL mid_rst_pix got=%0d,%0d exp=0,0", bus.pix_x, bus.pix_y); end
        if (bus.eng_grant !== 4'b0) begin errors++; $display("FAIL mid_rst_grant got=%b exp=0000", bus.eng_grant); end
        if (bus.frm_zoom !== 8'd0) begin errors++; $display("FAIL mid_rst_zoom got=%0d exp=0", bus.frm_zoom); end
        if (dut.outstanding_r !== 3'd0) begin errors++; $display("FAIL mid_rst_out got=%0d exp=0", dut.outstanding_r); end
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        // engines still in flight retire into an idle scheduler
        for (int k = 0; k < 4; k++) tick();
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got=%b exp=0", busy); end
        if (dut.outstanding_r !== 3'd0) begin errors++; $display("FAIL post_rst_out got=%0d exp=0", dut.outstanding_r); end
    endtask

    task automatic test_random_frames();
        int n;
        for (int f = 0; f < 3; f++) begin
            do_reset();
            lat = $urandom_range(1, 5);
            pan_x = coord_t'($urandom); pan_y = coord_t'($urandom); zoom = 8'($urandom);
            rdy_mask = 4'($urandom);
            start_in = 1'b1; tick(); start_in = 1'b0;
            n = 0;
            while (m_phase != P_IDLE && n < 2000) begin
                rdy_mask = 4'($urandom);
                start_in = ($urandom_range(0, 15) == 0);
                if (start_in) zoom = 8'($urandom);
                tick();
                start_in = 1'b0;
                n++;
                checks += 7;
                if (obs_grant !== exp_grant) begin errors++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, obs_grant, exp_grant); end
                if (bus.pix_x !== 10'(m_idx % H) || bus.pix_y !== 10'(m_idx / H)) begin
                    errors++; $display("FAIL rnd_pix cyc=%0d got=%0d,%0d exp=%0d,%0d", cyc, bus.pix_x, bus.pix_y, m_idx % H, m_idx / H);
                end
                if (busy !== (m_phase != P_IDLE)) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b", cyc, busy); end
                if (frame_done !== (m_phase == P_DONE)) begin errors++; $display("FAIL rnd_done cyc=%0d got=%b", cyc, frame_done); end
                if (bus.frm_zoom !== m_fz) begin errors++; $display("FAIL rnd_zoom cyc=%0d got=%0d exp=%0d", cyc, bus.frm_zoom, m_fz); end
                if (bus.frm_pan_x !== m_fx || bus.frm_pan_y !== m_fy) begin errors++; $display("FAIL rnd_pan cyc=%0d got=%h,%h exp=%h,%h", cyc, bus.frm_pan_x, bus.frm_pan_y, m_fx, m_fy); end
                if (dut.outstanding_r !== 3'(m_out)) begin errors++; $display("FAIL rnd_out cyc=%0d got=%0d exp=%0d", cyc, dut.outstanding_r, m_out); end
`ifdef PIXEL_SCHEDULER_STALL_CNT_EN
                checks++;
                if (stall_cycles !== 32'(m_stall)) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", cyc, stall_cycles, m_stall); end
`endif
            end
            checks++;
            if (m_phase != P_IDLE) begin errors++; $display("FAIL rnd_timeout frame=%0d got=busy exp=idle", f); end
        end
    endtask

`ifdef PIXEL_SCHEDULER_STALL_CNT_EN
    task automatic test_stall();
        bit ok;
        do_reset();
        lat = 2; rdy_mask = '0;
        start_in = 1'b1; tick(); start_in = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        checks++;
        if (stall_cycles !== 32'd10) begin errors++; $display("FAIL stall_ten got=%0d exp=10", stall_cycles); end
        rdy_mask = '1;
        run_to_idle(NPIX + 40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_timeout got=busy exp=idle"); end
    endtask
`endif

    initial begin
        rst_n = 1'b1; start = 1'b0; start_in = 1'b0;
        pan_x = 32'sd0; pan_y = 32'sd0; zoom = 8'd0;
        bus.eng_ready = '0; bus.eng_retire = '0;
        extra_ret = '0; rdy_mask = '1; lat = 3;
        for (int e = 0; e < N; e++) e_cnt[e] = 0;
        model_reset();
        #1 rst_n = 1'b0;
        test_reset();
        test_full_frame();
        test_pointer_pattern();
        test_outstanding();
        test_start_ignored_and_reset();
        test_random_frames();
`ifdef PIXEL_SCHEDULER_STALL_CNT_EN
        test_stall();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pixel_scheduler.md
PIXEL_SCHEDULER -- requirements
Module: pixel_scheduler

Interface
REQ-001 Parameter H_RES, default 640, active pixels per line.
REQ-002 Parameter V_RES, default 480, active lines per frame.
REQ-003 Parameter NUM_ENG, default 4, number of iteration engines served (2..8).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  frame request pulse; honoured only in IDLE.
REQ-007 pan_x, pan_y  in  32 each  view offsets, Q8.24 signed; sampled on accepted start.
REQ-008 zoom  in  8  view zoom shift; sampled on accepted start.
REQ-009 frm_pan_x, frm_pan_y  out  32 each  latched offsets driving the screen mapper for the whole frame.
REQ-010 frm_zoom  out  8  latched zoom driving the screen mapper.
REQ-011 pix_x  out  10 and pix_y  out  10  coordinate currently offered to the mapper/engines.
REQ-012 eng_ready  in  NUM_ENG  per-engine idle flag.
REQ-013 eng_grant  out  NUM_ENG  one-hot dispatch strobe; the granted engine captures pix_x/pix_y and mapper output this cycle.
REQ-014 eng_retire  in  NUM_ENG  per-engine one-cycle pulse on pixel completion (several may pulse together).
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 frame_done  out  1  one-cycle pulse at frame completion.

Function
REQ-017 FSM states IDLE, SCAN, DRAIN, DONE; IDLE->SCAN on start; SCAN->DRAIN on dispatch of pixel (H_RES-1, V_RES-1); DRAIN->DONE when outstanding count is 0; DONE->IDLE unconditionally after one cycle.
REQ-018 On accepted start: pan_x/pan_y/zoom latched into frm_* outputs, pix_x=pix_y=0, round-robin pointer unchanged.
REQ-019 start in SCAN, DRAIN or DONE ignored; frm_* change only on accepted start.
REQ-020 eng_grant is combinational, nonzero only in SCAN, selecting the first ready engine at or after the round-robin pointer, wrapping modulo NUM_ENG.
REQ-021 On a grant the pointer advances to granted index+1 (mod NUM_ENG) and pix_x advances next cycle; no grant -> pix_x/pix_y/pointer hold.
REQ-022 pix_x wraps H_RES-1 -> 0 with pix_y+1; the last pixel causes no further coordinate change.
REQ-023 Sustained rate: one pixel per cycle while any engine is ready; zero bubble at line wrap.
REQ-024 Outstanding counter, width clog2(NUM_ENG+1): +1 per grant, minus popcount(eng_retire) same cycle; simultaneous grant and retire net correctly.
REQ-025 A retire with outstanding 0 is ignored (counter saturates at 0); it never underflows.
REQ-026 frame_done asserts exactly in DONE; busy falls on the DONE->IDLE edge.

Reset
REQ-027 rst_n low, even mid-frame, forces IDLE, pix_x=pix_y=0, pointer 0, outstanding 0, frm_* 0, busy 0, frame_done 0, eng_grant 0; in-flight engine results are discarded by ignoring further retires until the next frame.

Configuration
REQ-028 Macro PIXEL_SCHEDULER_STALL_CNT_EN: when defined, an extra output stall_cycles (32 bits) counts SCAN cycles with no grant, cleared on accepted start, saturating at all-ones; when undefined the port and counter are absent and behaviour is otherwise identical.

Structure
REQ-029 Shared package mandel_pkg holds H_RES, V_RES defaults, the FSM state enum, and the Q8.24 coordinate typedef used by frm_pan_x/frm_pan_y.
REQ-030 One sub-module rr_arbiter (NUM_ENG-wide request/pointer -> one-hot grant plus next pointer, combinational) is instantiated once.

Verification
REQ-031 Reset, start with pan_x=0xFF000000, zoom=8, all engines ready, retire 3 cycles after grant -> 307200 grants in 307200 consecutive SCAN cycles, frame_done once, frm_zoom=8.
REQ-032 eng_ready=4'b1010, pointer 0 -> grants 4'b0010, then 4'b1000, then 4'b0010 on consecutive cycles.
REQ-033 pix_x=639, pix_y=5, grant -> next cycle pix_x=0, pix_y=6.
REQ-034 Grant and two retires same cycle with outstanding=3 -> outstanding=2; retire with outstanding=0 -> stays 0.
REQ-035 start pulsed mid-SCAN with new zoom=12 -> frm_zoom unchanged, no restart; rst_n low at pixel (100,50) -> IDLE, busy=0, pix_x=pix_y=0.
REQ-036 With PIXEL_SCHEDULER_STALL_CNT_EN and eng_ready=0 for 10 SCAN cycles -> stall_cycles=10.
